// File: rtl/nv_nvdla_sync_fifo_param.sv
// Parametrised single-clock flop-array FIFO with valid/ready handshake,
// runtime write limit, synchronous flush, occupancy and almost-full outputs.
module nv_nvdla_sync_fifo_param #(
  parameter  int unsigned DW        = 6,
  parameter  int unsigned DEPTH     = 128,
  parameter  int unsigned AF_MARGIN = 4,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_req,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  input  logic          flush,
  input  logic [CW-1:0] wr_limit,
  output logic [CW-1:0] wr_count,
  output logic          almost_full
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] lim;
  logic          push;
  logic          pop;

  // Zero or out-of-range limits fall back to the full depth.
  always_comb begin
    lim = DEPTH_C;
    if (wr_limit != '0 && wr_limit <= DEPTH_C) begin
      lim = wr_limit;
    end
  end

  // Handshake derived from registered occupancy only; rd_ready never feeds wr_ready.
  always_comb begin
    wr_ready    = !flush && (count < lim);
    rd_req      = (count != '0);
    rd_data     = rd_req ? mem[rd_ptr] : '0;
    wr_count    = count;
    almost_full = (count >= AF_LEVEL);
    push        = wr_req && wr_ready;
    pop         = rd_req && rd_ready && !flush;
  end

  // Pointer and occupancy state; flush wins over any concurrent pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule
